fuzzy_gain_scheduler: RTL and testbench

Multi-channel, parametrised fuzzy-logic gain scheduler for the closed-loop velocity controllers. For each accepted velocity sample it computes the error and the change in error magnitude for that channel, fuzzifies both into three classes, looks up target Kp/Kd in a fixed 3x3 rule table, and slews each channel's stored gains toward the target. It sits between the velocity measurement path and the per-channel PID blocks. It replaces the single-channel, fixed-width tuner with parametrised width, channel count, thresholds, gain levels and slew-rate limiting.

---
 rtl/fuzzy_gain_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_fuzzy_gain_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_gain_scheduler.sv
// Multi-channel fuzzy gain scheduler: per-sample error/trend fuzzification,
// 3x3 rule lookup of target Kp/Kd, and slew-limited per-channel gain update.
module fuzzy_gain_scheduler #(
  parameter int unsigned VEL_W   = 10,
  parameter int unsigned GAIN_W  = 4,
  parameter int unsigned NCH     = 2,
  parameter int unsigned E_SMALL = 16,
  parameter int unsigned E_LARGE = 64,
  parameter int unsigned D_ZERO  = 4,
  parameter int unsigned KP_MIN  = 2,
  parameter int unsigned KP_MID  = 6,
  parameter int unsigned KP_MAX  = 12,
  parameter int unsigned KD_MIN  = 1,
  parameter int unsigned KD_MID  = 4,
  parameter int unsigned KD_MAX  = 8,
  parameter int unsigned SLEW    = 2,
  localparam int unsigned CH_W   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [VEL_W-1:0]  target_vel,
  input  logic [VEL_W-1:0]  current_vel,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [GAIN_W-1:0] Kp,
  output logic [GAIN_W-1:0] Kd,
  output logic              out_large
);

  localparam int unsigned D_W = VEL_W + 1;
  localparam logic signed [D_W-1:0] DZ_POS = D_W'(D_ZERO);
  localparam logic signed [D_W-1:0] DZ_NEG = -DZ_POS;

  // Per-channel state
  logic [VEL_W-1:0]  prev_abs [NCH];
  logic              first    [NCH];
  logic [GAIN_W-1:0] kp_r     [NCH];
  logic [GAIN_W-1:0] kd_r     [NCH];

  // Stage 1 registers: magnitude and trend of the accepted sample
  logic                  s1_valid;
  logic [CH_W-1:0]       s1_ch;
  logic [VEL_W-1:0]      s1_a;
  logic signed [D_W-1:0] s1_d;

  // Stage 2 registers: rule-table targets
  logic              s2_valid;
  logic [CH_W-1:0]   s2_ch;
  logic [GAIN_W-1:0] s2_kp_t;
  logic [GAIN_W-1:0] s2_kd_t;
  logic              s2_large;

  logic                  accept_c;
  logic signed [D_W-1:0] err_c;
  logic [VEL_W-1:0]      a_c;
  logic [VEL_W-1:0]      p_c;
  logic signed [D_W-1:0] d_c;

  // Acceptance, signed error, magnitude and change in magnitude
  always_comb begin
    accept_c = in_valid & enable & (32'(in_ch) < NCH);
    err_c    = $signed({1'b0, target_vel}) - $signed({1'b0, current_vel});
    a_c      = err_c[VEL_W] ? VEL_W'(-err_c) : err_c[VEL_W-1:0];
    p_c      = first[in_ch] ? a_c : prev_abs[in_ch];
    d_c      = $signed({1'b0, a_c}) - $signed({1'b0, p_c});
  end

  // Stage 1: capture sample and update channel history in the accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_a     <= '0;
      s1_d     <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        prev_abs[i] <= '0;
        first[i]    <= 1'b1;
      end
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_ch           <= in_ch;
        s1_a            <= a_c;
        s1_d            <= d_c;
        prev_abs[in_ch] <= a_c;
        first[in_ch]    <= 1'b0;
      end
    end
  end

  logic              small_c;
  logic              large_c;
  logic              grow_c;
  logic              fall_c;
  logic [GAIN_W-1:0] kp_t_c;
  logic [GAIN_W-1:0] kd_t_c;

  // Fuzzification and rule table
  always_comb begin
    small_c = s1_a < VEL_W'(E_SMALL);
    large_c = s1_a >= VEL_W'(E_LARGE);
    grow_c  = s1_d > DZ_POS;
    fall_c  = s1_d < DZ_NEG;
    kp_t_c  = GAIN_W'(KP_MID);
    kd_t_c  = GAIN_W'(KD_MID);
    if (large_c) begin
      kp_t_c = GAIN_W'(KP_MAX);
      kd_t_c = GAIN_W'(KD_MIN);
    end else if (small_c) begin
      if (fall_c) begin
        kp_t_c = GAIN_W'(KP_MIN);
        kd_t_c = GAIN_W'(KD_MAX);
      end else if (grow_c) begin
        kp_t_c = GAIN_W'(KP_MID);
        kd_t_c = GAIN_W'(KD_MID);
      end else begin
        kp_t_c = GAIN_W'(KP_MIN);
        kd_t_c = GAIN_W'(KD_MID);
      end
    end else begin
      if (fall_c) begin
        kp_t_c = GAIN_W'(KP_MID);
        kd_t_c = GAIN_W'(KD_MAX);
      end else if (grow_c) begin
        kp_t_c = GAIN_W'(KP_MAX);
        kd_t_c = GAIN_W'(KD_MID);
      end else begin
        kp_t_c = GAIN_W'(KP_MID);
        kd_t_c = GAIN_W'(KD_MID);
      end
    end
  end

  // Stage 2: register the targets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_kp_t  <= '0;
      s2_kd_t  <= '0;
      s2_large <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ch    <= s1_ch;
        s2_kp_t  <= kp_t_c;
        s2_kd_t  <= kd_t_c;
        s2_large <= large_c;
      end
    end
  end

  // Move g toward t by at most SLEW
  function automatic logic [GAIN_W-1:0] slew_step(input logic [GAIN_W-1:0] g,
                                                  input logic [GAIN_W-1:0] t);
    logic [GAIN_W-1:0] r;
    if (t >= g) r = ((t - g) <= GAIN_W'(SLEW)) ? t : g + GAIN_W'(SLEW);
    else        r = ((g - t) <= GAIN_W'(SLEW)) ? t : g - GAIN_W'(SLEW);
    return r;
  endfunction

  logic [GAIN_W-1:0] kp_new_c;
  logic [GAIN_W-1:0] kd_new_c;

  // Slewed gains for the channel in the update stage
  always_comb begin
    kp_new_c = slew_step(kp_r[s2_ch], s2_kp_t);
    kd_new_c = slew_step(kd_r[s2_ch], s2_kd_t);
  end

  // Gain read-modify-write and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      Kp        <= '0;
      Kd        <= '0;
      out_large <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        kp_r[i] <= GAIN_W'(KP_MID);
        kd_r[i] <= GAIN_W'(KD_MID);
      end
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        kp_r[s2_ch] <= kp_new_c;
        kd_r[s2_ch] <= kd_new_c;
        out_ch      <= s2_ch;
        Kp          <= kp_new_c;
        Kd          <= kd_new_c;
        out_large   <= s2_large;
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_gain_scheduler.sv
// Self-checking bench for fuzzy_gain_scheduler (NCH=3): directed scenarios
// followed by randomized traffic against a behavioural reference model.
module tb_fuzzy_gain_scheduler;

  localparam int NCH  = 3;
  localparam int SLEW = 2;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [9:0] target_vel;
  logic [9:0] current_vel;
  logic       out_valid;
  logic [1:0] out_ch;
  logic [3:0] Kp;
  logic [3:0] Kd;
  logic       out_large;

  fuzzy_gain_scheduler #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ch(in_ch), .target_vel(target_vel), .current_vel(current_vel),
    .out_valid(out_valid), .out_ch(out_ch), .Kp(Kp), .Kd(Kd),
    .out_large(out_large)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_kp [NCH];
  int m_kd [NCH];
  int m_prev [NCH];
  bit m_first [NCH];
  // Expected results in flight: index 2 is the one due now
  bit pv [3];
  int pch [3];
  int pkp [3];
  int pkd [3];
  bit plg [3];
  int h_ch, h_kp, h_kd;
  bit h_lg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int slew_to(input int g, input int t);
    if (t > g) return (t - g <= SLEW) ? t : g + SLEW;
    else       return (g - t <= SLEW) ? t : g - SLEW;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_kp[i] = 6; m_kd[i] = 4; m_prev[i] = 0; m_first[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    h_ch = 0; h_kp = 0; h_kd = 0; h_lg = 1'b0;
  endtask

  // Evaluate one accepted sample from the rule description and push it into slot 0
  task automatic model_sample(input int ch, input int tv, input int cv);
    int a, p, d, tkp, tkd;
    int ec, tc;
    a = tv - cv;
    if (a < 0) a = -a;
    p = m_first[ch] ? a : m_prev[ch];
    d = a - p;
    m_prev[ch] = a;
    m_first[ch] = 1'b0;
    ec = (a < 16) ? 0 : (a < 64) ? 1 : 2;
    tc = (d > 4) ? 2 : (d < -4) ? 0 : 1;
    if (ec == 2)              begin tkp = 12; tkd = 1; end
    else if (ec == 0 && tc == 0) begin tkp = 2;  tkd = 8; end
    else if (ec == 0 && tc == 1) begin tkp = 2;  tkd = 4; end
    else if (ec == 0)            begin tkp = 6;  tkd = 4; end
    else if (tc == 0)            begin tkp = 6;  tkd = 8; end
    else if (tc == 1)            begin tkp = 6;  tkd = 4; end
    else                         begin tkp = 12; tkd = 4; end
    m_kp[ch] = slew_to(m_kp[ch], tkp);
    m_kd[ch] = slew_to(m_kd[ch], tkd);
    pv[0] = 1'b1; pch[0] = ch; pkp[0] = m_kp[ch]; pkd[0] = m_kd[ch]; plg[0] = (ec == 2);
  endtask

  // Drive one cycle of input, advance the model, check outputs on the falling edge
  task automatic step(input bit v, input bit en, input int ch, input int tv, input int cv);
    int c2;
    c2 = ch;
    in_valid = v; enable = en; in_ch = c2[1:0];
    target_vel = tv[9:0]; current_vel = cv[9:0];
    @(posedge clk);
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; pch[i] = pch[i-1]; pkp[i] = pkp[i-1]; pkd[i] = pkd[i-1]; plg[i] = plg[i-1];
    end
    pv[0] = 1'b0;
    if (v && en && ch < NCH) model_sample(ch, tv, cv);
    if (pv[2]) begin
      h_ch = pch[2]; h_kp = pkp[2]; h_kd = pkd[2]; h_lg = plg[2];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(pv[2]));
    chk("out_ch", 32'(out_ch), h_ch);
    chk("Kp", 32'(Kp), h_kp);
    chk("Kd", 32'(Kd), h_kd);
    chk("out_large", 32'(out_large), 32'(h_lg));
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 0, 0, 0);
  endtask

  // Asynchronous reset pulse of one cycle, launched on a falling edge
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_Kp", 32'(Kp), 0);
    chk("rst_Kd", 32'(Kd), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v, en, ch, tv, cv;
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_ch = '0;
    target_vel = '0; current_vel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_ch", 32'(out_ch), 0);
    chk("reset_Kp", 32'(Kp), 0);
    chk("reset_Kd", 32'(Kd), 0);
    chk("reset_out_large", 32'(out_large), 0);
    rst_n = 1'b1;
    idle();

    // First sample, M-Z
    step(1, 1, 0, 50, 11);
    idle();
    idle();
    chk("tp1_valid", 32'(out_valid), 1);
    chk("tp1_kp", 32'(Kp), 6);
    chk("tp1_kd", 32'(Kd), 4);
    chk("tp1_large", 32'(out_large), 0);

    // Large error three times back-to-back on the same channel
    step(1, 1, 0, 200, 11);
    step(1, 1, 0, 200, 11);
    step(1, 1, 0, 200, 11);
    chk("l1_kp", 32'(Kp), 8);
    chk("l1_kd", 32'(Kd), 2);
    idle();
    chk("l2_kp", 32'(Kp), 10);
    chk("l2_kd", 32'(Kd), 1);
    idle();
    chk("l3_kp", 32'(Kp), 12);
    chk("l3_kd", 32'(Kd), 1);
    chk("l3_large", 32'(out_large), 1);

    // Interleaved channel 1 traffic
    step(1, 1, 1, 20, 30);
    step(1, 1, 0, 200, 11);
    step(1, 1, 1, 20, 40);
    chk("ch1a_kp", 32'(Kp), 4);
    chk("ch1a_ch", 32'(out_ch), 1);
    idle();
    chk("ch0_kp_kept", 32'(Kp), 12);
    idle();
    chk("ch1b_kp", 32'(Kp), 6);
    chk("ch1b_kd", 32'(Kd), 4);

    // Converging run on channel 0
    step(1, 1, 0, 100, 40);
    step(1, 1, 0, 100, 50);
    step(1, 1, 0, 100, 90);
    step(1, 1, 0, 100, 92);
    idle(); idle();

    // Dropped samples
    step(1, 0, 0, 500, 0);
    step(1, 1, 3, 500, 0);
    idle(); idle();
    step(1, 1, 0, 100, 92);
    idle(); idle();

    // Class and trend boundaries on channel 2
    step(1, 1, 2, 16, 0);
    step(1, 1, 2, 64, 0);
    step(1, 1, 2, 0, 20);
    step(1, 1, 2, 24, 0);
    step(1, 1, 2, 20, 0);
    idle(); idle();

    // Reset one cycle after an accept
    step(1, 1, 0, 300, 0);
    pulse_reset();
    idle();
    step(1, 1, 0, 50, 11);
    idle(); idle();
    chk("post_rst_kp", 32'(Kp), 6);
    chk("post_rst_kd", 32'(Kd), 4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom % 4) != 0;
      en = ($urandom % 8) != 0;
      ch = $urandom % 4;
      tv = $urandom % 1024;
      if ($urandom % 4 != 0) begin
        cv = tv + int'($urandom % 161) - 80;
        if (cv < 0) cv = 0;
        if (cv > 1023) cv = 1023;
      end else begin
        cv = $urandom % 1024;
      end
      step(v[0], en[0], ch, tv, cv);
      if (n == 200) pulse_reset();
    end
    idle(); idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
